lcd1602_responder: RTL and testbench

HD44780-compatible display-side responder for the LCD1602 8-bit parallel bus. It samples the RS/RW/E/D bus that the LCD1602 writer drives, executes instructions, and stores characters in an 80-byte DDRAM. It drives busy-flag, address-counter and DDRAM reads back onto the bus. A second registered read port lets a downstream renderer, such as a VGA or UART mirror, fetch screen contents, so the board can emulate or mirror the panel.

---
 rtl/lcd1602_responder.sv | 240 ++++++++++++++++++++++++
 tb/tb_lcd1602_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/lcd1602_responder.sv
// HD44780-compatible display-side responder for the LCD1602 8-bit bus.
// Samples the writer's RS/RW/E/D bus, executes instructions, stores text in
// an 80-byte DDRAM, drives read-back data and offers a renderer read port.
module lcd1602_responder #(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76500
) (
    input  logic       FPGA_CLK,
    input  logic       FPGA_RST_N,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    input  logic       LCD_E,
    input  logic [7:0] LCD_D,
    output logic [7:0] LCD_DOUT,
    output logic       LCD_DOE,
    output logic       BUSY,
    output logic [6:0] AC,
    output logic       DISP_ON,
    output logic       CURSOR_ON,
    output logic       BLINK_ON,
    output logic       TWO_LINE,
    output logic [5:0] SHIFT,
    output logic       OVERRUN,
    input  logic [6:0] RD_ADDR,
    output logic [7:0] RD_DATA
);
    localparam int CW = $clog2(BUSY_LONG + 1);
    localparam logic [CW-1:0] SHORT_M1 = CW'(BUSY_SHORT - 1);
    localparam logic [CW-1:0] LONG_M1  = CW'(BUSY_LONG - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

    typedef enum logic [1:0] {
        ST_RST_CLR = 2'd0,
        ST_IDLE    = 2'd1,
        ST_EXEC    = 2'd2,
        ST_WAIT    = 2'd3
    } state_t;

    // AC is legal for the current line mode
    function automatic logic ac_valid(input logic [6:0] a, input logic two);
        if (two) ac_valid = (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
        else     ac_valid = (a <= 7'h4F);
    endfunction

    // DDRAM index: line*40 + column in two-line mode
    function automatic logic [6:0] ac_index(input logic [6:0] a, input logic two);
        if (two) ac_index = a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
        else     ac_index = a;
    endfunction

    // AC +/-1 with the line-mode wrap points
    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic two, input logic up);
        if (!two) begin
            if (up) ac_step = (a >= 7'h4F) ? 7'h00 : a + 7'd1;
            else    ac_step = (a == 7'h00) ? 7'h4F : a - 7'd1;
        end else begin
            if (up) begin
                if (a == 7'h27)      ac_step = 7'h40;
                else if (a >= 7'h67) ac_step = 7'h00;
                else                 ac_step = a + 7'd1;
            end else begin
                if (a == 7'h40)      ac_step = 7'h27;
                else if (a == 7'h00) ac_step = 7'h67;
                else                 ac_step = a - 7'd1;
            end
        end
    endfunction

    // Display shift +/-1 modulo 40
    function automatic logic [5:0] shift_step(input logic [5:0] s, input logic up);
        if (up) shift_step = (s >= 6'd39) ? 6'd0 : s + 6'd1;
        else    shift_step = (s == 6'd0) ? 6'd39 : s - 6'd1;
    endfunction

    logic       e_s1_r, e_s2_r, e_q_r, rs_s1_r, rs_s2_r, rw_s1_r, rw_s2_r;
    logic [7:0] d_s1_r, d_s2_r;
    logic       strobe_r, cmd_rs_r, cmd_rw_r;
    logic [7:0] cmd_d_r;

    state_t        state_r, state_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic [6:0]    fill_r, fill_nxt, ac_r, ac_nxt;
    logic [5:0]    shift_r, shift_nxt;
    logic busy_r, busy_nxt, id_r, id_nxt, s_r, s_nxt, ramsel_r, ramsel_nxt;
    logic disp_r, disp_nxt, cur_r, cur_nxt, blink_r, blink_nxt;
    logic two_r, two_nxt, ovr_r, ovr_nxt;
    logic [7:0] dout_r, rd_data_r;
    logic       doe_r;

    logic [7:0] mem_r [0:79];
    logic       mem_we_s;
    logic [6:0] mem_waddr_s;
    logic [7:0] mem_wdata_s;
    logic       is_status_s;
    logic [7:0] bus_rd_s;

    assign is_status_s = ~cmd_rs_r & cmd_rw_r;
    assign bus_rd_s    = ac_valid(ac_r, two_r) ? mem_r[ac_index(ac_r, two_r)] : 8'h20;

    // Two-flop synchronizers, E edge register and strobe/command capture
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            e_s1_r <= 1'b0; e_s2_r <= 1'b0; e_q_r <= 1'b0;
            rs_s1_r <= 1'b0; rs_s2_r <= 1'b0; rw_s1_r <= 1'b0; rw_s2_r <= 1'b0;
            d_s1_r <= 8'h00; d_s2_r <= 8'h00;
            strobe_r <= 1'b0; cmd_rs_r <= 1'b0; cmd_rw_r <= 1'b0; cmd_d_r <= 8'h00;
        end else begin
            e_s1_r <= LCD_E;  e_s2_r <= e_s1_r; e_q_r <= e_s2_r;
            rs_s1_r <= LCD_RS; rs_s2_r <= rs_s1_r;
            rw_s1_r <= LCD_RW; rw_s2_r <= rw_s1_r;
            d_s1_r <= LCD_D;  d_s2_r <= d_s1_r;
            strobe_r <= e_q_r & ~e_s2_r;
            cmd_rs_r <= rs_s2_r; cmd_rw_r <= rw_s2_r; cmd_d_r <= d_s2_r;
        end
    end

    // Next-state logic: init/clear fill, instruction and data execution, busy timing
    always_comb begin
        state_nxt = state_r;  cnt_nxt = cnt_r;    fill_nxt = fill_r;   busy_nxt = busy_r;
        ac_nxt = ac_r;        id_nxt = id_r;      s_nxt = s_r;         ramsel_nxt = ramsel_r;
        disp_nxt = disp_r;    cur_nxt = cur_r;    blink_nxt = blink_r; two_nxt = two_r;
        shift_nxt = shift_r;  ovr_nxt = ovr_r;
        mem_we_s = 1'b0;      mem_waddr_s = fill_r; mem_wdata_s = 8'h20;

        if (strobe_r && busy_r && !is_status_s) ovr_nxt = 1'b1;
        else                                   ovr_nxt = ovr_r;

        case (state_r)
            ST_RST_CLR, ST_EXEC: begin
                mem_we_s = (fill_r < 7'd80);
                fill_nxt = (fill_r < 7'd80) ? fill_r + 7'd1 : fill_r;
                if (cnt_r == CNT_ZERO) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    if (fill_r >= 7'd79) state_nxt = ST_WAIT;
                    else                 state_nxt = state_r;
                end
            end
            ST_IDLE: begin
                if (strobe_r && !is_status_s) begin
                    busy_nxt  = 1'b1;
                    state_nxt = ST_WAIT;
                    cnt_nxt   = SHORT_M1;
                    if (!cmd_rs_r && !cmd_rw_r) begin
                        casez (cmd_d_r)
                            8'b1???????: begin
                                ramsel_nxt = 1'b0;
                                ac_nxt = ac_valid(cmd_d_r[6:0], two_r) ? cmd_d_r[6:0] : 7'h00;
                            end
                            8'b01??????: ramsel_nxt = 1'b1;
                            8'b001?????: two_nxt = cmd_d_r[3];
                            8'b0001????: begin
                                if (cmd_d_r[3]) shift_nxt = shift_step(shift_r, cmd_d_r[2]);
                                else            ac_nxt = ac_step(ac_r, two_r, cmd_d_r[2]);
                            end
                            8'b00001???: begin
                                disp_nxt = cmd_d_r[2]; cur_nxt = cmd_d_r[1]; blink_nxt = cmd_d_r[0];
                            end
                            8'b000001??: begin
                                id_nxt = cmd_d_r[1]; s_nxt = cmd_d_r[0];
                            end
                            8'b0000001?: begin
                                ac_nxt = 7'h00; shift_nxt = 6'd0; cnt_nxt = LONG_M1;
                            end
                            8'b00000001: begin
                                ac_nxt = 7'h00; id_nxt = 1'b1; shift_nxt = 6'd0;
                                fill_nxt = 7'd0; cnt_nxt = LONG_M1; state_nxt = ST_EXEC;
                            end
                            default: cnt_nxt = SHORT_M1;
                        endcase
                    end else if (cmd_rs_r && !cmd_rw_r) begin
                        if (!ramsel_r) begin
                            mem_we_s    = ac_valid(ac_r, two_r);
                            mem_waddr_s = ac_index(ac_r, two_r);
                            mem_wdata_s = cmd_d_r;
                            ac_nxt      = ac_step(ac_r, two_r, id_r);
                            if (s_r) shift_nxt = shift_step(shift_r, id_r);
                            else     shift_nxt = shift_r;
                        end else begin
                            mem_we_s = 1'b0;
                        end
                    end else begin
                        ac_nxt = ac_step(ac_r, two_r, id_r);
                    end
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt_r - {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt = ST_RST_CLR; busy_nxt = 1'b1; cnt_nxt = LONG_M1; fill_nxt = 7'd0;
            end
        endcase
    end

    // Control/status registers; reset restarts the init clear
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            state_r <= ST_RST_CLR; cnt_r <= LONG_M1; fill_r <= 7'd0; busy_r <= 1'b1;
            ac_r <= 7'h00; id_r <= 1'b1; s_r <= 1'b0; ramsel_r <= 1'b0;
            disp_r <= 1'b0; cur_r <= 1'b0; blink_r <= 1'b0; two_r <= 1'b0;
            shift_r <= 6'd0; ovr_r <= 1'b0;
        end else begin
            state_r <= state_nxt; cnt_r <= cnt_nxt; fill_r <= fill_nxt; busy_r <= busy_nxt;
            ac_r <= ac_nxt; id_r <= id_nxt; s_r <= s_nxt; ramsel_r <= ramsel_nxt;
            disp_r <= disp_nxt; cur_r <= cur_nxt; blink_r <= blink_nxt; two_r <= two_nxt;
            shift_r <= shift_nxt; ovr_r <= ovr_nxt;
        end
    end

    // DDRAM write port (no reset: contents are rebuilt by the init clear)
    always_ff @(posedge FPGA_CLK) begin
        if (mem_we_s) mem_r[mem_waddr_s] <= mem_wdata_s;
    end

    // Registered bus read-back and renderer read port
    always_ff @(posedge FPGA_CLK or negedge FPGA_RST_N) begin
        if (!FPGA_RST_N) begin
            doe_r <= 1'b0; dout_r <= 8'h00; rd_data_r <= 8'h00;
        end else begin
            doe_r     <= e_s2_r & rw_s2_r;
            dout_r    <= (e_s2_r & rw_s2_r) ? (rs_s2_r ? bus_rd_s : {busy_r, ac_r}) : 8'h00;
            rd_data_r <= (RD_ADDR < 7'd80) ? mem_r[RD_ADDR] : 8'h20;
        end
    end

    assign LCD_DOUT = dout_r;   assign LCD_DOE  = doe_r;   assign BUSY     = busy_r;
    assign AC       = ac_r;     assign DISP_ON  = disp_r;  assign CURSOR_ON = cur_r;
    assign BLINK_ON = blink_r;  assign TWO_LINE = two_r;   assign SHIFT    = shift_r;
    assign OVERRUN  = ovr_r;    assign RD_DATA  = rd_data_r;
endmodule

// File: tb/tb_lcd1602_responder.sv
// Directed, table-driven bench for lcd1602_responder (short busy timings).
module tb_lcd1602_responder;
    localparam int BS = 4;
    localparam int BL = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       lcd_rs = 1'b0, lcd_rw = 1'b0, lcd_e = 1'b0;
    logic [7:0] lcd_d = 8'h00;
    logic [7:0] lcd_dout, rd_data;
    logic       lcd_doe, busy, disp_on, cursor_on, blink_on, two_line, overrun;
    logic [6:0] ac, rd_addr = 7'd0;
    logic [5:0] shift;

    always #5 clk = ~clk;

    lcd1602_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL)) dut (
        .FPGA_CLK(clk), .FPGA_RST_N(rst_n),
        .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_E(lcd_e), .LCD_D(lcd_d),
        .LCD_DOUT(lcd_dout), .LCD_DOE(lcd_doe), .BUSY(busy), .AC(ac),
        .DISP_ON(disp_on), .CURSOR_ON(cursor_on), .BLINK_ON(blink_on),
        .TWO_LINE(two_line), .SHIFT(shift), .OVERRUN(overrun),
        .RD_ADDR(rd_addr), .RD_DATA(rd_data)
    );

    int checks = 0;
    int failures = 0;

    // length of the most recent completed busy period, in cycles
    int run_cnt = 0;
    int last_run = 0;
    always @(negedge clk) begin
        if (!rst_n) run_cnt = 0;
        else if (busy) run_cnt = run_cnt + 1;
        else if (run_cnt != 0) begin
            last_run = run_cnt;
            run_cnt = 0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // one bus access: 8 cycles E high (read-back sampled mid-pulse), 8 low
    task automatic bus_access(input logic rs, input logic rw, input logic [7:0] d,
                              output logic [7:0] dout, output logic doe);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_d = d; lcd_e = 1'b1;
        dout = 8'h00; doe = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 4) begin dout = lcd_dout; doe = lcd_doe; end
        end
        lcd_e = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin @(negedge clk); n++; end
        chk("idle_timeout", (n >= 400) ? 32'd1 : 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic rd_check(input string name, input logic [6:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(name, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_dout"}, {24'd0, lcd_dout}, 32'h00);
        chk({tag, "_doe"}, {31'd0, lcd_doe}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_ac"}, {25'd0, ac}, 32'h00);
        chk({tag, "_ctrl"}, {28'd0, disp_on, cursor_on, blink_on, two_line}, 32'd0);
        chk({tag, "_shift"}, {26'd0, shift}, 32'd0);
        chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
        chk({tag, "_rd_data"}, {24'd0, rd_data}, 32'h00);
    endtask

    // hold reset, check reset values, release and check the init clear
    task automatic reset_release(input string tag);
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals({tag, "_held"});
        @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin n++; @(negedge clk); end
        chk({tag, "_init_busy_len"}, n, BL);
        chk({tag, "_init_ac"}, {25'd0, ac}, 32'h00);
        for (int i = 0; i < 80; i++) rd_check({tag, "_init_fill"}, 7'(i), 8'h20);
        rd_check({tag, "_rd_oob"}, 7'd127, 8'h20);
    endtask

    typedef struct {
        logic       rs;
        logic       rw;
        logic [7:0] d;
        logic [6:0] exp_ac;
        logic [2:0] exp_flags;   // {TWO_LINE, DISP_ON, CURSOR_ON}
        logic [5:0] exp_shift;
        logic [7:0] exp_dout;    // compared only for reads
        int         exp_run;
        logic [6:0] rd_a;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [22];
    logic [7:0] dout_v;
    logic       doe_v;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 8'h38, 7'h00, 3'b100, 6'd0,  8'h00, BS, 7'd0,   8'h20};
        vecs[1]  = '{1'b0, 1'b0, 8'h0C, 7'h00, 3'b110, 6'd0,  8'h00, BS, 7'd79,  8'h20};
        vecs[2]  = '{1'b0, 1'b0, 8'h06, 7'h00, 3'b110, 6'd0,  8'h00, BS, 7'd100, 8'h20};
        vecs[3]  = '{1'b0, 1'b0, 8'h01, 7'h00, 3'b110, 6'd0,  8'h00, BL, 7'd0,   8'h20};
        vecs[4]  = '{1'b1, 1'b0, 8'h48, 7'h01, 3'b110, 6'd0,  8'h00, BS, 7'd0,   8'h48};
        vecs[5]  = '{1'b1, 1'b0, 8'h49, 7'h02, 3'b110, 6'd0,  8'h00, BS, 7'd1,   8'h49};
        vecs[6]  = '{1'b0, 1'b0, 8'h1C, 7'h02, 3'b110, 6'd1,  8'h00, BS, 7'd2,   8'h20};
        vecs[7]  = '{1'b0, 1'b0, 8'h18, 7'h02, 3'b110, 6'd0,  8'h00, BS, 7'd2,   8'h20};
        vecs[8]  = '{1'b0, 1'b0, 8'h18, 7'h02, 3'b110, 6'd39, 8'h00, BS, 7'd2,   8'h20};
        vecs[9]  = '{1'b0, 1'b0, 8'h1C, 7'h02, 3'b110, 6'd0,  8'h00, BS, 7'd2,   8'h20};
        vecs[10] = '{1'b0, 1'b0, 8'h10, 7'h01, 3'b110, 6'd0,  8'h00, BS, 7'd2,   8'h20};
        vecs[11] = '{1'b0, 1'b0, 8'h14, 7'h02, 3'b110, 6'd0,  8'h00, BS, 7'd2,   8'h20};
        vecs[12] = '{1'b0, 1'b1, 8'h00, 7'h02, 3'b110, 6'd0,  8'h02, BS, 7'd2,   8'h20};
        vecs[13] = '{1'b0, 1'b0, 8'h80, 7'h00, 3'b110, 6'd0,  8'h00, BS, 7'd2,   8'h20};
        vecs[14] = '{1'b1, 1'b1, 8'h00, 7'h01, 3'b110, 6'd0,  8'h48, BS, 7'd0,   8'h48};
        vecs[15] = '{1'b0, 1'b0, 8'hA7, 7'h27, 3'b110, 6'd0,  8'h00, BS, 7'd39,  8'h20};
        vecs[16] = '{1'b1, 1'b0, 8'h41, 7'h40, 3'b110, 6'd0,  8'h00, BS, 7'd39,  8'h41};
        vecs[17] = '{1'b1, 1'b0, 8'h42, 7'h41, 3'b110, 6'd0,  8'h00, BS, 7'd40,  8'h42};
        vecs[18] = '{1'b0, 1'b0, 8'h04, 7'h41, 3'b110, 6'd0,  8'h00, BS, 7'd40,  8'h42};
        vecs[19] = '{1'b0, 1'b0, 8'h80, 7'h00, 3'b110, 6'd0,  8'h00, BS, 7'd0,   8'h48};
        vecs[20] = '{1'b1, 1'b0, 8'h43, 7'h67, 3'b110, 6'd0,  8'h00, BS, 7'd0,   8'h43};
        vecs[21] = '{1'b0, 1'b0, 8'hE8, 7'h00, 3'b110, 6'd0,  8'h00, BS, 7'd1,   8'h49};

        // power-up: reset values, 100-cycle busy, DDRAM filled with spaces
        reset_release("por");

        // main table
        for (int k = 0; k < 22; k++) begin
            bus_access(vecs[k].rs, vecs[k].rw, vecs[k].d, dout_v, doe_v);
            wait_idle();
            chk($sformatf("v%0d_ac", k), {25'd0, ac}, {25'd0, vecs[k].exp_ac});
            chk($sformatf("v%0d_flags", k), {29'd0, two_line, disp_on, cursor_on},
                {29'd0, vecs[k].exp_flags});
            chk($sformatf("v%0d_shift", k), {26'd0, shift}, {26'd0, vecs[k].exp_shift});
            chk($sformatf("v%0d_busy_len", k), last_run, vecs[k].exp_run);
            chk($sformatf("v%0d_doe", k), {31'd0, doe_v}, {31'd0, vecs[k].rw});
            if (vecs[k].rw)
                chk($sformatf("v%0d_dout", k), {24'd0, dout_v}, {24'd0, vecs[k].exp_dout});
            rd_check($sformatf("v%0d_rd", k), vecs[k].rd_a, vecs[k].exp_rd);
        end
        chk("blink_off", {31'd0, blink_on}, 32'd0);

        // access while busy: home (long busy), then data 'Z' and a status read
        chk("overrun_pre", {31'd0, overrun}, 32'd0);
        bus_access(1'b0, 1'b0, 8'h02, dout_v, doe_v);
        chk("home_busy", {31'd0, busy}, 32'd1);
        bus_access(1'b1, 1'b0, 8'h5A, dout_v, doe_v);
        bus_access(1'b0, 1'b1, 8'h00, dout_v, doe_v);
        chk("busy_status_dout", {24'd0, dout_v}, 32'h80);
        chk("busy_status_doe", {31'd0, doe_v}, 32'd1);
        wait_idle();
        chk("home_busy_len", last_run, BL);
        chk("overrun_set", {31'd0, overrun}, 32'd1);
        chk("overrun_ac", {25'd0, ac}, 32'h00);
        rd_check("overrun_ddram0", 7'd0, 8'h43);
        rd_check("overrun_ddram1", 7'd1, 8'h49);

        // reset in the middle of a clear fill
        @(negedge clk);
        lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_d = 8'h01; lcd_e = 1'b1;
        repeat (8) @(negedge clk);
        lcd_e = 1'b0;
        begin
            int n = 0;
            while (!busy && n < 20) begin @(negedge clk); n++; end
            chk("clear_busy_rise", {31'd0, busy}, 32'd1);
        end
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midfill");
        reset_release("rerst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
